// File: rtl/uart_tx_pkg.sv
// Shared definitions for the memory-mapped UART transmitter.
// Holds the register word offsets (dev_addr[3:2]), the serialiser state
// encoding and the bit positions of the STATUS register.
package uart_tx_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_DIV    = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  localparam int unsigned STAT_BUSY    = 0;
  localparam int unsigned STAT_FULL    = 1;
  localparam int unsigned STAT_EMPTY   = 2;
  localparam int unsigned STAT_CNT_LSB = 4;
  localparam int unsigned STAT_CNT_MSB = 8;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO holding bytes waiting for transmission.
// Ports:
//   clk, rst      clock, asynchronous active-high reset (empties the FIFO)
//   push, din     write request and data; ignored when full
//   pop, dout     read request and head-of-queue data; ignored when empty
//   full, empty   occupancy flags
//   count         number of stored entries (0..DEPTH)
module uart_tx_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign dout    = mem[rd_ptr_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_comb begin
    count_d = count_q;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/dev_uart_tx.sv
// Memory-mapped 8N1 UART transmitter (IO hub device slot 3).
// Ports:
//   clk, rst   system clock, asynchronous active-high reset
//   irq        level interrupt: ie & FIFO empty & transmitter idle (registered)
//   dev_out    combinational read data selected by dev_addr[3:2]
//   dev_in     write data; dev_we one-cycle write strobe
//   dev_addr   byte offset in slot; only [3:2] decoded
//   txd        serial output, idle high
module dev_uart_tx
  import uart_tx_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [15:0] DIV_RESET  = 16'd433
) (
  input  logic        clk,
  input  logic        rst,
  output logic        irq,
  output logic [31:0] dev_out,
  input  logic [31:0] dev_in,
  input  logic [7:0]  dev_addr,
  input  logic        dev_we,
  output logic        txd
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  logic [1:0]    sel;
  logic          push, pop;
  logic [7:0]    fifo_dout;
  logic          fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;

  tx_state_e     state_q, state_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [15:0]   div_q, div_d;
  logic          ie_q, ie_d;
  logic          txd_q, txd_d;
  logic          irq_q, irq_d;
  logic          bit_end;
  logic          busy;

  logic unused_bits;
  assign unused_bits = ^{dev_in[31:16], dev_addr[7:4], dev_addr[1:0]};

  assign sel  = dev_addr[3:2];
  assign push = dev_we & (sel == REG_DATA);
  assign busy = (state_q != IDLE);

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (dev_in[7:0]),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    ie_d  = ie_q;
    div_d = div_q;
    if (dev_we && sel == REG_CTRL) ie_d  = dev_in[0];
    if (dev_we && sel == REG_DIV)  div_d = dev_in[15:0];
  end

  // Period counter reloads from div_d so a DIVISOR write landing in the last
  // cycle of a bit period already governs the period that starts next.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    pop       = 1'b0;
    bit_end   = (cnt_q == 16'd0);
    if (busy && !bit_end) cnt_d = cnt_q - 16'd1;

    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_dout;
          cnt_d   = div_d;
          state_d = START;
        end
      end
      START: begin
        if (bit_end) begin
          bit_idx_d = 3'd0;
          cnt_d     = div_d;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          cnt_d   = div_d;
          if (bit_idx_q == 3'd7) state_d = STOP;
          else                   bit_idx_d = bit_idx_q + 3'd1;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = fifo_dout;
            cnt_d   = div_d;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // txd is registered from next-state values: glitch-free, no extra latency.
    unique case (state_d)
      START:   txd_d = 1'b0;
      DATA:    txd_d = shift_d[0];
      default: txd_d = 1'b1;
    endcase

    irq_d = ie_q & fifo_empty & ~busy;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      div_q     <= DIV_RESET;
      ie_q      <= 1'b0;
      txd_q     <= 1'b1;
      irq_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      div_q     <= div_d;
      ie_q      <= ie_d;
      txd_q     <= txd_d;
      irq_q     <= irq_d;
    end
  end

  assign txd = txd_q;
  assign irq = irq_q;

  always_comb begin
    dev_out = 32'd0;
    unique case (sel)
      REG_STATUS: begin
        dev_out[STAT_BUSY]                   = busy;
        dev_out[STAT_FULL]                   = fifo_full;
        dev_out[STAT_EMPTY]                  = fifo_empty;
        dev_out[STAT_CNT_MSB:STAT_CNT_LSB]   = 5'(fifo_count);
      end
      REG_CTRL: dev_out[0]    = ie_q;
      REG_DIV:  dev_out[15:0] = div_q;
      default:  dev_out       = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_dev_uart_tx.sv
// Self-checking bench for dev_uart_tx: a scoreboard queue of expected bytes
// is filled by the stimulus and drained by a txd monitor that decodes 8N1
// frames from the configured bit period.
module tb_dev_uart_tx;
  import uart_tx_pkg::*;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        irq;
  logic [31:0] dev_out;
  logic [31:0] dev_in;
  logic [7:0]  dev_addr;
  logic        dev_we;
  logic        txd;

  int checks = 0;
  int errors = 0;
  int cur_div = 433;
  int cyc = 0;
  byte unsigned exp_q[$];
  int start_times[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dev_uart_tx #(
    .FIFO_DEPTH (DEPTH),
    .DIV_RESET  (16'd433)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .irq      (irq),
    .dev_out  (dev_out),
    .dev_in   (dev_in),
    .dev_addr (dev_addr),
    .dev_we   (dev_we),
    .txd      (txd)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Caller is positioned away from posedge; returns at the next negedge.
  task automatic wr(input logic [1:0] r, input logic [31:0] d);
    dev_addr = {4'h0, r, 2'b00};
    dev_in   = d;
    dev_we   = 1'b1;
    @(negedge clk);
    dev_we   = 1'b0;
  endtask

  task automatic wr_byte(input byte unsigned b);
    if (exp_q.size() < DEPTH) exp_q.push_back(b);
    wr(REG_DATA, {24'h0, b});
  endtask

  task automatic set_div(input int d);
    wr(REG_DIV, d);
    cur_div = d;
  endtask

  task automatic rd(input logic [1:0] r, output logic [31:0] v);
    dev_addr = {4'h0, r, 2'b00};
    #1;
    v = dev_out;
  endtask

  task automatic rd_check(input logic [1:0] r, input logic [31:0] exp, input string name);
    logic [31:0] v;
    rd(r, v);
    check(name, v, exp);
  endtask

  task automatic wait_txd_low(input string name);
    bit ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (txd === 1'b0) begin
        ok = 1;
        break;
      end
    end
    check(name, {31'b0, ok}, 32'd1);
  endtask

  task automatic wait_idle(input string name);
    bit ok = 0;
    logic [31:0] v;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      rd(REG_STATUS, v);
      if (!v[0] && v[2] && exp_q.size() == 0) begin
        ok = 1;
        break;
      end
    end
    check(name, {31'b0, ok}, 32'd1);
  endtask

  // Monitor: decodes each frame and compares it with the scoreboard head.
  initial begin : monitor
    logic [9:0] bits;
    bit have_exp;
    bit aborted;
    bit ok;
    int p;
    byte unsigned b;
    forever begin
      @(negedge clk);
      if (rst !== 1'b1 && txd === 1'b0) begin
        start_times.push_back(cyc);
        p = cur_div + 1;
        have_exp = (exp_q.size() != 0);
        if (!have_exp) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame: frame started at cycle %0d, expected none", cyc);
          bits = 10'h3ff;
        end else begin
          b = exp_q.pop_front();
          bits = {1'b1, b, 1'b0};
        end
        aborted = 0;
        for (int k = 0; k < 10; k++) begin
          ok = 1;
          for (int c = 0; c < p; c++) begin
            if (k != 0 || c != 0) @(negedge clk);
            if (rst === 1'b1) begin
              aborted = 1;
              break;
            end
            if (txd !== bits[k]) ok = 0;
          end
          if (aborted) break;
          if (have_exp) begin
            checks++;
            if (!ok) begin
              errors++;
              $display("FAIL frame_bit: byte 0x%0h bit slot %0d got wrong level, required %0b",
                       b, k, bits[k]);
            end
          end
        end
      end
    end
  end

  initial begin : watchdog
    #900_000;
    errors++;
    $display("FAIL timeout: simulation did not complete, got hang, required finish");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [31:0] v;
    int bad;
    int ns;
    bit ok;
    rst = 1'b0;
    dev_we = 1'b0;
    dev_addr = 8'h0;
    dev_in = 32'h0;

    // Reset asserted asynchronously mid-cycle.
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_txd", {31'b0, txd}, 32'd1);
    check("rst_irq", {31'b0, irq}, 32'd0);
    @(negedge clk);
    rd_check(REG_STATUS, 32'h4, "rst_status");
    rd_check(REG_DIV, 32'd433, "rst_div");
    rd_check(REG_CTRL, 32'd0, "rst_ctrl");
    rd_check(REG_DATA, 32'd0, "data_reads_zero");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Single frame, 4 clocks per bit.
    set_div(3);
    rd_check(REG_DIV, 32'd3, "div_readback");
    wr(REG_STATUS, 32'hffff_ffff);
    rd_check(REG_STATUS, 32'h4, "status_write_ignored");
    wr_byte(8'h55);
    wait_txd_low("single_start");
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      if (i > 0) @(negedge clk);
      rd(REG_STATUS, v);
      if (!v[0]) bad++;
    end
    check("busy_during_frame", bad, 0);
    @(negedge clk);
    rd(REG_STATUS, v);
    check("idle_after_40", {31'b0, v[0]}, 32'd0);
    wait_idle("single_drain");

    // Back-to-back frames at one clock per bit.
    set_div(0);
    ns = start_times.size();
    wr_byte(8'hA5);
    rd_check(REG_STATUS, 32'h10, "b2b_count_first");
    wr_byte(8'h3C);
    rd_check(REG_STATUS, 32'h11, "b2b_count_second");
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      #1;
      if (start_times.size() >= ns + 2) begin
        ok = 1;
        break;
      end
    end
    check("b2b_second_frame", {31'b0, ok}, 32'd1);
    rd_check(REG_STATUS, 32'h5, "b2b_empty_after_pop");
    if (ok) check("b2b_no_gap", start_times[ns+1] - start_times[ns], 32'd10);
    wait_idle("b2b_drain");

    // FIFO full while the transmitter is busy with an in-flight byte.
    set_div(2);
    wr_byte(8'hEE);
    wait_txd_low("full_start");
    for (int i = 1; i <= 9; i++) wr_byte(byte'(i));
    rd_check(REG_STATUS, 32'h83, "full_status");
    wait_idle("full_drain");

    // Interrupt behaviour.
    set_div(3);
    wr_byte(8'h0F);
    wr(REG_CTRL, 32'h1);
    check("irq_txd_start", {31'b0, txd}, 32'd0);
    bad = 0;
    for (int i = 0; i < 41; i++) begin
      if (i > 0) @(negedge clk);
      if (irq !== 1'b0) bad++;
    end
    check("irq_low_during_frame", bad, 0);
    @(negedge clk);
    check("irq_rise", {31'b0, irq}, 32'd1);
    wr(REG_CTRL, 32'h0);
    @(negedge clk);
    check("irq_ie_clear", {31'b0, irq}, 32'd0);
    wr(REG_CTRL, 32'h1);
    @(negedge clk);
    check("irq_reenable", {31'b0, irq}, 32'd1);
    wr_byte(8'h77);
    @(negedge clk);
    check("irq_data_clear", {31'b0, irq}, 32'd0);
    wait_idle("irq_drain");
    wr(REG_CTRL, 32'h0);

    // Reset during DATA bit 3 with more bytes queued.
    wr_byte(8'hC3);
    wr_byte(8'h11);
    wr_byte(8'h22);
    repeat (16) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_txd", {31'b0, txd}, 32'd1);
    exp_q.delete();
    cur_div = 433;
    rd_check(REG_STATUS, 32'h4, "midrst_status");
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (txd !== 1'b1) bad++;
    end
    check("midrst_no_residual", bad, 0);

    // Randomised bursts with random gaps and divisors.
    for (int r = 0; r < 5; r++) begin
      int n;
      set_div($urandom_range(0, 2));
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) begin
        wr_byte(byte'($urandom_range(0, 255)));
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      wait_idle("random_drain");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
